// File: rtl/pipe_ctrl.sv
`timescale 1ns/1ps
// pipe_ctrl: pipeline sequencer sitting between fetch, decode/regfile, ALU and writeback.
// Owns the fetch PC, the per-stage valid bits, a per-register RAW scoreboard, stall/flush
// generation and two saturating perf counters.
// Stage 0 = fetch, 1 = decode, 2..NSTAGES-1 = execute..writeback; issue is decode -> stage 2.
//
// Ports
//   iClk, iRst            clock, asynchronous active-low reset
//   iInstValid            fetch returns an instruction this cycle
//   iRs1Addr/iRs1Used     decode source 1 and whether it is read
//   iRs2Addr/iRs2Used     decode source 2 and whether it is read
//   iRdAddr/iRdWe         decode destination and write enable
//   iBrTaken/iBrTarget    stage-2 taken branch and its redirect PC
//   iWbValid/iWbRd        writeback retires a write to iWbRd
//   oPc                   fetch address
//   oStageValid           per-stage valid bits
//   oStallF/oStallD       hold fetch / hold decode on a RAW hazard
//   oFlush                kill stages 0 and 1
//   oIssue                decode instruction advances to stage 2
//   oStallCnt/oRetireCnt  saturating perf counters (stall cycles, retired instructions)
module pipe_ctrl #(
  parameter int unsigned  NSTAGES   = 4,
  parameter int unsigned  NREGS     = 32,
  parameter int unsigned  RAW       = 5,
  parameter int unsigned  PCW       = 32,
  parameter logic [PCW-1:0] RESET_PC = '0,
  parameter bit           BYPASS_WB = 1'b0,
  parameter int unsigned  CNTW      = 32
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iInstValid,
  input  logic [RAW-1:0]     iRs1Addr,
  input  logic               iRs1Used,
  input  logic [RAW-1:0]     iRs2Addr,
  input  logic               iRs2Used,
  input  logic [RAW-1:0]     iRdAddr,
  input  logic               iRdWe,
  input  logic               iBrTaken,
  input  logic [PCW-1:0]     iBrTarget,
  input  logic               iWbValid,
  input  logic [RAW-1:0]     iWbRd,
  output logic [PCW-1:0]     oPc,
  output logic [NSTAGES-1:0] oStageValid,
  output logic               oStallF,
  output logic               oStallD,
  output logic               oFlush,
  output logic               oIssue,
  output logic [CNTW-1:0]    oStallCnt,
  output logic [CNTW-1:0]    oRetireCnt
);

  // Each counter holds the number of in-flight writers (stages 2..NSTAGES-1) of one register.
  localparam int unsigned SBW = $clog2(NSTAGES + 1);

  if (NSTAGES < 3) begin : g_bad_depth
    $error("pipe_ctrl: NSTAGES must be at least 3");
  end
  if (RAW != $clog2(NREGS)) begin : g_bad_raw
    $error("pipe_ctrl: RAW must equal clog2(NREGS)");
  end

  logic [PCW-1:0]     pc_q, pc_d;
  logic [NSTAGES-1:0] valid_q, valid_d;
  logic [SBW-1:0]     sb_cnt_q [NREGS];
  logic [SBW-1:0]     sb_cnt_d [NREGS];
  logic [CNTW-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0]    retire_cnt_q, retire_cnt_d;

  logic flush;
  logic stall_d;
  logic issue;
  logic rs1_pend;
  logic rs2_pend;
  logic sb_inc_en;
  logic sb_dec_en;
  logic sb_ovf;
  logic sb_unf;

  // ---------------------------------------------------------------------------------------------
  // Hazard detection and pipeline control
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    logic [SBW-1:0] cnt1;
    logic [SBW-1:0] cnt2;
    logic           wb_hit1;
    logic           wb_hit2;

    cnt1    = sb_cnt_q[iRs1Addr];
    cnt2    = sb_cnt_q[iRs2Addr];
    wb_hit1 = iWbValid && (iWbRd == iRs1Addr);
    wb_hit2 = iWbValid && (iWbRd == iRs2Addr);

    // With the writeback bypass, the last outstanding writer retiring this cycle supplies the
    // value directly, so the source is no longer considered pending.
    rs1_pend = iRs1Used && (iRs1Addr != '0) && (cnt1 != '0) &&
               !(BYPASS_WB && wb_hit1 && (cnt1 == SBW'(1)));
    rs2_pend = iRs2Used && (iRs2Addr != '0) && (cnt2 != '0) &&
               !(BYPASS_WB && wb_hit2 && (cnt2 == SBW'(1)));

    flush   = valid_q[2] && iBrTaken;
    // A flush kills the stalled decode instruction, so it overrides the stall.
    stall_d = valid_q[1] && (rs1_pend || rs2_pend) && !flush;
    issue   = valid_q[1] && !stall_d && !flush;
  end

  // ---------------------------------------------------------------------------------------------
  // Scoreboard next state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    logic inc;
    logic dec;

    sb_inc_en = issue && iRdWe && (iRdAddr != '0);
    sb_dec_en = iWbValid && (iWbRd != '0);
    sb_ovf    = 1'b0;
    sb_unf    = 1'b0;
    inc       = 1'b0;
    dec       = 1'b0;

    for (int unsigned r = 0; r < NREGS; r++) begin
      sb_cnt_d[r] = sb_cnt_q[r];
    end
    // x0 is never tracked.
    sb_cnt_d[0] = '0;

    for (int unsigned r = 1; r < NREGS; r++) begin
      inc = sb_inc_en && (iRdAddr == RAW'(r));
      dec = sb_dec_en && (iWbRd == RAW'(r));
      // Simultaneous set and clear of the same register cancel out.
      if (inc && !dec) begin
        if (sb_cnt_q[r] == '1) begin
          sb_ovf = 1'b1;
        end else begin
          sb_cnt_d[r] = sb_cnt_q[r] + SBW'(1);
        end
      end else if (dec && !inc) begin
        if (sb_cnt_q[r] == '0) begin
          sb_unf = 1'b1;
        end else begin
          sb_cnt_d[r] = sb_cnt_q[r] - SBW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // PC, valid bits and perf counters next state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;

    if (flush) begin
      pc_d = iBrTarget;
    end else if (!stall_d && iInstValid) begin
      pc_d = pc_q + PCW'(4);
    end

    if (flush) begin
      valid_d[0] = 1'b0;
      valid_d[1] = 1'b0;
    end else if (!stall_d) begin
      valid_d[1] = valid_q[0];
      valid_d[0] = iInstValid;
    end

    // A stalled decode sends a bubble into stage 2; later stages never stall.
    valid_d[2] = issue;
    for (int unsigned k = 3; k < NSTAGES; k++) begin
      valid_d[k] = valid_q[k-1];
    end

    stall_cnt_d  = stall_cnt_q;
    retire_cnt_d = retire_cnt_q;
    if (stall_d && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
    if (valid_q[NSTAGES-1] && (retire_cnt_q != '1)) begin
      retire_cnt_d = retire_cnt_q + CNTW'(1);
    end
  end

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      pc_q         <= RESET_PC;
      valid_q      <= '0;
      stall_cnt_q  <= '0;
      retire_cnt_q <= '0;
      for (int unsigned r = 0; r < NREGS; r++) begin
        sb_cnt_q[r] <= '0;
      end
    end else begin
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      stall_cnt_q  <= stall_cnt_d;
      retire_cnt_q <= retire_cnt_d;
      for (int unsigned r = 0; r < NREGS; r++) begin
        sb_cnt_q[r] <= sb_cnt_d[r];
      end
    end
  end

  // Writeback of a register with no outstanding writer, or more writers than the counter holds,
  // means the surrounding pipeline is broken.
  a_sb_no_overflow:  assert property (@(posedge iClk) disable iff (!iRst) !sb_ovf);
  a_sb_no_underflow: assert property (@(posedge iClk) disable iff (!iRst) !sb_unf);

  assign oPc         = pc_q;
  assign oStageValid = valid_q;
  assign oStallD     = stall_d;
  assign oStallF     = stall_d;
  assign oFlush      = flush;
  assign oIssue      = issue;
  assign oStallCnt   = stall_cnt_q;
  assign oRetireCnt  = retire_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
`timescale 1ns/1ps
// Bench for pipe_ctrl. Two instances: dut0 (no bypass, 32-bit counters, reset PC 0) and dut1
// (writeback bypass, 4-bit counters, reset PC near the top of the address space so the PC wraps).
// Each instance has its own reference model: an array of instruction slots, one per stage.
// Hazards are found by scanning the in-flight slots for writers of a source register.
module tb_pipe_ctrl;

  localparam int N = 4;
  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] RPC1 = 32'hFFFF_FFF0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        inst_valid [2];
  logic [4:0]  rs1 [2];
  logic        u1 [2];
  logic [4:0]  rs2 [2];
  logic        u2 [2];
  logic [4:0]  rd [2];
  logic        we [2];
  logic        br [2];
  logic [31:0] tgt [2];
  logic        wbv [2];
  logic [4:0]  wbrd [2];

  logic [31:0]  pc [2];
  logic [N-1:0] sv [2];
  logic         st_d [2];
  logic         st_f [2];
  logic         fl [2];
  logic         iss [2];
  logic [31:0]  scnt0, rcnt0;
  logic [3:0]   scnt1, rcnt1;

  pipe_ctrl #(
    .NSTAGES(N), .NREGS(32), .RAW(5), .PCW(32), .RESET_PC(RPC0), .BYPASS_WB(1'b0), .CNTW(32)
  ) u_dut0 (
    .iClk(clk), .iRst(rst_n), .iInstValid(inst_valid[0]),
    .iRs1Addr(rs1[0]), .iRs1Used(u1[0]), .iRs2Addr(rs2[0]), .iRs2Used(u2[0]),
    .iRdAddr(rd[0]), .iRdWe(we[0]), .iBrTaken(br[0]), .iBrTarget(tgt[0]),
    .iWbValid(wbv[0]), .iWbRd(wbrd[0]),
    .oPc(pc[0]), .oStageValid(sv[0]), .oStallF(st_f[0]), .oStallD(st_d[0]),
    .oFlush(fl[0]), .oIssue(iss[0]), .oStallCnt(scnt0), .oRetireCnt(rcnt0)
  );

  pipe_ctrl #(
    .NSTAGES(N), .NREGS(32), .RAW(5), .PCW(32), .RESET_PC(RPC1), .BYPASS_WB(1'b1), .CNTW(4)
  ) u_dut1 (
    .iClk(clk), .iRst(rst_n), .iInstValid(inst_valid[1]),
    .iRs1Addr(rs1[1]), .iRs1Used(u1[1]), .iRs2Addr(rs2[1]), .iRs2Used(u2[1]),
    .iRdAddr(rd[1]), .iRdWe(we[1]), .iBrTaken(br[1]), .iBrTarget(tgt[1]),
    .iWbValid(wbv[1]), .iWbRd(wbrd[1]),
    .oPc(pc[1]), .oStageValid(sv[1]), .oStallF(st_f[1]), .oStallD(st_d[1]),
    .oFlush(fl[1]), .oIssue(iss[1]), .oStallCnt(scnt1), .oRetireCnt(rcnt1)
  );

  typedef struct {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic [4:0] a1;
    logic       u1;
    logic [4:0] a2;
    logic       u2;
  } slot_t;

  typedef struct {
    logic [31:0]  pc;
    logic [N-1:0] v;
    logic         stall;
    logic         flush;
    logic         issue;
    logic [31:0]  sc;
    logic [31:0]  rc;
  } exp_t;

  slot_t       ms [2][N];
  logic [31:0] mpc [2];
  int          mstall [2];
  int          mret [2];
  exp_t        q0[$];
  exp_t        q1[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          seq_rd = 0;

  function automatic int cntw(int d);
    return (d == 1) ? 4 : 32;
  endfunction

  function automatic logic [31:0] sat(int x, int w);
    if (w >= 32) return 32'(x);
    if (x > (1 << w) - 1) return 32'((1 << w) - 1);
    return 32'(x);
  endfunction

  // A source is pending while any older instruction in stages 2..N-1 still has to write it.
  function automatic logic pending(int d, logic used, logic [4:0] a);
    int w = 0;
    if (!used || a == 5'd0) return 1'b0;
    for (int k = 2; k < N; k++) begin
      if (ms[d][k].v && ms[d][k].we && ms[d][k].rd == a) w++;
    end
    // dut1 forwards the retiring value when it comes from the only remaining writer.
    if (d == 1 && w == 1 && ms[d][N-1].v && ms[d][N-1].we && ms[d][N-1].rd == a) return 1'b0;
    return w != 0;
  endfunction

  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL dut%0d %s: got %h, expected %h (t=%0t)", d, nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mpc[d]    = (d == 1) ? RPC1 : RPC0;
      mstall[d] = 0;
      mret[d]   = 0;
      for (int k = 0; k < N; k++) ms[d][k] = '{default: '0};
    end
  endtask

  task automatic drive_idle();
    for (int d = 0; d < 2; d++) begin
      inst_valid[d] = 1'b0; rs1[d] = '0; u1[d] = 1'b0; rs2[d] = '0; u2[d] = 1'b0;
      rd[d] = '0; we[d] = 1'b0; br[d] = 1'b0; tgt[d] = '0; wbv[d] = 1'b0; wbrd[d] = '0;
    end
  endtask

  task automatic check_reset();
    for (int d = 0; d < 2; d++) begin
      chk("rst_pc", d, pc[d], (d == 1) ? RPC1 : RPC0);
      chk("rst_valid", d, 32'(sv[d]), 32'd0);
      chk("rst_stall", d, {31'd0, st_d[d]}, 32'd0);
      chk("rst_flush", d, {31'd0, fl[d]}, 32'd0);
      chk("rst_issue", d, {31'd0, iss[d]}, 32'd0);
    end
    chk("rst_stallcnt", 0, scnt0, 32'd0);
    chk("rst_retirecnt", 0, rcnt0, 32'd0);
    chk("rst_stallcnt", 1, {28'd0, scnt1}, 32'd0);
    chk("rst_retirecnt", 1, {28'd0, rcnt1}, 32'd0);
  endtask

  // mode 0: independent stream (distinct rd, no sources read, no branches); mode 1: random.
  task automatic new_instr(int mode, output slot_t s);
    s.v = 1'b1;
    if (mode == 0) begin
      seq_rd++;
      s.rd = 5'(seq_rd); s.we = 1'b1;
      s.a1 = '0; s.u1 = 1'b0; s.a2 = '0; s.u2 = 1'b0;
    end else begin
      s.rd = 5'($urandom_range(0, 7));
      s.we = ($urandom_range(0, 3) != 0);
      s.a1 = 5'($urandom_range(0, 7));
      s.u1 = 1'($urandom_range(0, 1));
      s.a2 = 5'($urandom_range(0, 7));
      s.u2 = 1'($urandom_range(0, 1));
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, then advance the models.
  task automatic step(int mode, bit fetch_on);
    for (int d = 0; d < 2; d++) begin
      slot_t s1, sl, ns;
      exp_t  e;
      logic  f, st, is;
      int    pick;

      inst_valid[d] = (mode == 0) ? fetch_on : ($urandom_range(0, 9) < 8);
      br[d] = (mode != 0) && ($urandom_range(0, 11) == 0);
      pick = int'($urandom_range(0, 3));
      tgt[d] = (pick == 0) ? 32'h0000_0100 : (pick == 1) ? 32'hFFFF_FFF8 :
               ($urandom & 32'hFFFF_FFFC);

      s1 = ms[d][1];
      if (s1.v) begin
        rs1[d] = s1.a1; u1[d] = s1.u1; rs2[d] = s1.a2; u2[d] = s1.u2;
        rd[d] = s1.rd; we[d] = s1.we;
      end else begin
        rs1[d] = 5'($urandom_range(0, 7)); u1[d] = 1'($urandom_range(0, 1));
        rs2[d] = 5'($urandom_range(0, 7)); u2[d] = 1'($urandom_range(0, 1));
        rd[d] = 5'($urandom_range(0, 7)); we[d] = 1'($urandom_range(0, 1));
      end
      sl = ms[d][N-1];
      wbv[d]  = sl.v && sl.we;
      wbrd[d] = sl.v ? sl.rd : 5'($urandom_range(0, 7));

      f  = ms[d][2].v && br[d];
      st = s1.v && (pending(d, s1.u1, s1.a1) || pending(d, s1.u2, s1.a2)) && !f;
      is = s1.v && !st && !f;

      e.pc = mpc[d];
      for (int k = 0; k < N; k++) e.v[k] = ms[d][k].v;
      e.stall = st; e.flush = f; e.issue = is;
      e.sc = sat(mstall[d], cntw(d));
      e.rc = sat(mret[d], cntw(d));
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);

      if (st) mstall[d]++;
      if (sl.v) mret[d]++;
      for (int k = N - 1; k >= 3; k--) ms[d][k] = ms[d][k-1];
      ms[d][2]   = s1;
      ms[d][2].v = is;
      if (f) begin
        ms[d][0].v = 1'b0;
        ms[d][1].v = 1'b0;
        mpc[d]     = tgt[d];
      end else if (!st) begin
        ms[d][1] = ms[d][0];
        if (inst_valid[d]) begin
          new_instr(mode, ns);
          ms[d][0] = ns;
          mpc[d]   = mpc[d] + 32'd4;
        end else begin
          ms[d][0].v = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_dut(int d, exp_t e);
    chk("pc", d, pc[d], e.pc);
    chk("stage_valid", d, 32'(sv[d]), 32'(e.v));
    chk("stall_d", d, {31'd0, st_d[d]}, {31'd0, e.stall});
    chk("stall_f", d, {31'd0, st_f[d]}, {31'd0, e.stall});
    chk("flush", d, {31'd0, fl[d]}, {31'd0, e.flush});
    chk("issue", d, {31'd0, iss[d]}, {31'd0, e.issue});
    chk("stall_cnt", d, (d == 1) ? {28'd0, scnt1} : scnt0, e.sc);
    chk("retire_cnt", d, (d == 1) ? {28'd0, rcnt1} : rcnt0, e.rc);
  endtask

  // Monitor: pops the expectation queued for the current cycle, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() != 0) begin
      e = q0.pop_front();
      compare_dut(0, e);
    end
    if (q1.size() != 0) begin
      e = q1.pop_front();
      compare_dut(1, e);
    end
  end

  initial begin
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;

    // Eight independent instructions, then drain.
    repeat (8) begin
      step(0, 1'b1);
      @(posedge clk); #1;
    end
    repeat (8) begin
      step(0, 1'b0);
      @(posedge clk); #1;
    end
    chk("stream_retire", 0, rcnt0, 32'd8);
    chk("stream_retire", 1, {28'd0, rcnt1}, 32'd8);
    chk("stream_stalls", 0, scnt0, 32'd0);
    chk("stream_pc", 0, pc[0], 32'd32);
    chk("stream_pc_wrap", 1, pc[1], 32'h0000_0010);

    repeat (150) begin
      step(1, 1'b1);
      @(posedge clk); #1;
    end

    // Reset in the middle of traffic: takes effect without a clock edge.
    rst_n = 1'b0;
    #1;
    check_reset();
    drive_idle();
    model_reset();
    @(posedge clk); #1;
    check_reset();
    rst_n = 1'b1;

    repeat (400) begin
      step(1, 1'b1);
      @(posedge clk); #1;
    end
    @(negedge clk); #1;

    chk("queue_drained", 0, 32'(q0.size() + q1.size()), 32'd0);
    if (mstall[1] >= 15) chk("stall_saturated", 1, {28'd0, scnt1}, 32'd15);
    if (mret[1] >= 15)   chk("retire_saturated", 1, {28'd0, rcnt1}, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
